div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative RV32M divide/remainder unit, downstream of regfile.
//  Consumes o_rs1_data/o_rs2_data for DIV/DIVU/REM/REMU.
//  Returns the result on a rd write port that is muxed into regfile
//  i_rd_addr/i_rd_data/i_rd_wren.
//  Radix-2 restoring divider: one quotient bit per clock. Core stalls on o_busy.
// PARAMETERS
//  DW      32  operand/result width (RV32: 32)
//  AW      5   register address width
// PORTS
//  i_clk       in   1   clock, all state on rising edge
//  i_rst_n     in   1   asynchronous active-low reset
//  i_start     in   1   request; accepted only in IDLE
//  i_op        in   2   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  i_rs1_data  in   DW  dividend
//  i_rs2_data  in   DW  divisor
//  i_rd_addr   in   AW  destination register
//  i_kill      in   1   synchronous abort, no writeback
//  o_busy      out  1   high in CALC and DONE
//  o_done      out  1   one-cycle result strobe
//  o_rd_wren   out  1   = o_done && (o_rd_addr != 0)
//  o_rd_addr   out  AW  registered i_rd_addr
//  o_rd_data   out  DW  quotient or remainder
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE.
//   o_busy, o_done, o_rd_wren, o_rd_addr, o_rd_data all 0; internal regs 0.
//  Reset mid-operation drops the operation silently; no writeback.
//  FSM IDLE -> CALC | DONE; CALC -> DONE | IDLE; DONE -> IDLE.
//  IDLE:
//   i_start=1 and i_kill=0: latch op, rd_addr, operands at edge E0.
//   Divisor==0 or signed overflow: go to DONE.
//   Otherwise: go to CALC with counter=DW-1.
//   i_kill=1 in IDLE: start is ignored.
//  CALC: one shift/subtract step per edge; counter decrements.
//   At counter==0: apply sign fix, register the result, go to DONE.
//   Normal op: o_done is high in the cycle after edge E0+DW (latency DW+1 clocks).
//   Special case: o_done is high in the cycle after E0 (latency 1 clock).
//  DONE: o_done=1 for exactly one cycle, then IDLE. i_start in DONE is ignored.
//   o_rd_data/o_rd_addr hold their values until the next result.
//  i_kill in CALC: go to IDLE next edge, no o_done.
//  i_kill in DONE: no effect; the strobe completes.
//  i_start while busy: ignored. No queuing; the caller holds the request.
//  Arithmetic:
//   Signed ops take magnitudes |a|, |b| and run an unsigned divide.
//   Quotient negated iff sign(a)!=sign(b); remainder takes sign(a).
//   Divisor==0: quotient = all ones; remainder = dividend (signed and unsigned).
//   DIV/REM with a=0x80000000, b=0xFFFFFFFF: q=0x80000000, r=0.
//   Widths: partial remainder DW+1 bits; no other state exceeds DW.
// TESTING
//  DIVU 100/7, rd=5 -> o_done at E0+33, o_rd_data=14, o_rd_wren=1, o_rd_addr=5.
//  REM -7/2 (0xFFFFFFF9,2) -> 0xFFFFFFFF. DIV -7/2 -> 0xFFFFFFFD.
//  DIV x/0, x=0x1234 -> 1-clock latency, 0xFFFFFFFF. REMU x/0 -> 0x1234.
//  DIV 0x80000000/-1 -> 0x80000000. REM same operands -> 0; 1-clock latency.
//  i_start in CALC ignored. i_kill at cycle 10 of CALC -> IDLE, no o_done.
//   A new start is then accepted the next cycle.
//  i_rst_n low at cycle 5 of CALC -> all outputs 0 immediately.
//   No strobe after release. rd=0 result -> o_done=1, o_rd_wren=0.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU unit.
// Radix-2 restoring divider that produces one quotient bit per clock.
// The result is presented as a one-cycle rd write strobe for the regfile.
// Divide-by-zero and signed overflow bypass the iteration and finish in one clock.
module div_unit #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic [DW-1:0] i_rs1_data,
  input  logic [DW-1:0] i_rs2_data,
  input  logic [AW-1:0] i_rd_addr,
  input  logic          i_kill,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_rd_wren,
  output logic [AW-1:0] o_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DW - 1);
  localparam logic [DW-1:0] INT_MIN  = {1'b1, {(DW-1){1'b0}}};

  // Control state
  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg;

  // Operation context captured at acceptance
  logic          op_rem_reg;   // 1: return remainder, 0: return quotient
  logic          neg_q_reg;    // quotient must be negated at the end
  logic          neg_r_reg;    // remainder must be negated at the end
  logic [AW-1:0] rd_addr_reg;

  // Iteration registers: quo_reg starts as the dividend magnitude and is
  // shifted left, its MSB feeding the partial remainder while quotient bits
  // enter from the right.
  logic [DW-1:0] quo_reg;
  logic [DW-1:0] rem_reg;
  logic [DW-1:0] dvs_reg;

  // Presented result, held until the next result is produced
  logic [DW-1:0] res_data_reg;
  logic [AW-1:0] res_addr_reg;

  // Request decode
  logic          accept;
  logic          is_signed;
  logic          a_neg, b_neg;
  logic [DW-1:0] a_mag, b_mag;
  logic          div_zero, overflow, special;
  logic [DW-1:0] special_res;

  // One restoring step
  logic [DW:0]   shift_val;
  logic [DW:0]   diff;
  logic          step_ok;
  logic [DW-1:0] rem_step;
  logic [DW-1:0] quo_step;
  logic [DW-1:0] fix_q, fix_r, calc_res;
  logic          last_step;

  assign accept    = (state_reg == ST_IDLE) && i_start && !i_kill;
  assign is_signed = ~i_op[0];
  assign a_neg     = is_signed & i_rs1_data[DW-1];
  assign b_neg     = is_signed & i_rs2_data[DW-1];
  assign a_mag     = a_neg ? (~i_rs1_data + 1'b1) : i_rs1_data;
  assign b_mag     = b_neg ? (~i_rs2_data + 1'b1) : i_rs2_data;
  assign div_zero  = (i_rs2_data == '0);
  assign overflow  = is_signed && (i_rs1_data == INT_MIN) && (&i_rs2_data);
  assign special   = div_zero || overflow;

  // Divide by zero: q = all ones, r = dividend.
  // Signed overflow: q = dividend (INT_MIN), r = 0.
  assign special_res = div_zero ? (i_op[1] ? i_rs1_data : '1)
                                : (i_op[1] ? '0 : i_rs1_data);

  // The partial remainder is DW+1 bits wide only for the trial subtraction;
  // it is always below the divisor afterwards, so DW bits of state suffice.
  assign shift_val = {rem_reg, quo_reg[DW-1]};
  assign diff      = shift_val - {1'b0, dvs_reg};
  assign step_ok   = ~diff[DW];
  assign rem_step  = step_ok ? diff[DW-1:0] : shift_val[DW-1:0];
  assign quo_step  = {quo_reg[DW-2:0], step_ok};

  assign fix_q     = neg_q_reg ? (~quo_step + 1'b1) : quo_step;
  assign fix_r     = neg_r_reg ? (~rem_step + 1'b1) : rem_step;
  assign calc_res  = op_rem_reg ? fix_r : fix_q;

  assign last_step = (state_reg == ST_CALC) && !i_kill && (cnt_reg == '0);

  // Next-state selection for IDLE/CALC/DONE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (i_kill)              state_next = ST_IDLE;
        else if (cnt_reg == '0)  state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset drops any operation in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Capture operands on acceptance, then run one shift/subtract per clock
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg     <= '0;
      op_rem_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rd_addr_reg <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dvs_reg     <= '0;
    end else if (accept) begin
      cnt_reg     <= CNT_LOAD;
      op_rem_reg  <= i_op[1];
      neg_q_reg   <= a_neg ^ b_neg;
      neg_r_reg   <= a_neg;
      rd_addr_reg <= i_rd_addr;
      quo_reg     <= a_mag;
      rem_reg     <= '0;
      dvs_reg     <= b_mag;
    end else if ((state_reg == ST_CALC) && !i_kill) begin
      cnt_reg     <= cnt_reg - CW'(1);
      quo_reg     <= quo_step;
      rem_reg     <= rem_step;
    end
  end

  // Result register: written by the bypass path or by the last iteration
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_data_reg <= '0;
      res_addr_reg <= '0;
    end else if (accept && special) begin
      res_data_reg <= special_res;
      res_addr_reg <= i_rd_addr;
    end else if (last_step) begin
      res_data_reg <= calc_res;
      res_addr_reg <= rd_addr_reg;
    end
  end

  assign o_busy    = (state_reg != ST_IDLE);
  assign o_done    = (state_reg == ST_DONE);
  assign o_rd_wren = o_done && (res_addr_reg != '0);
  assign o_rd_addr = res_addr_reg;
  assign o_rd_data = res_data_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit, one task per scenario.
module tb_div_unit;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [1:0]    i_op;
  logic [DW-1:0] i_rs1_data;
  logic [DW-1:0] i_rs2_data;
  logic [AW-1:0] i_rd_addr;
  logic          i_kill;
  logic          o_busy;
  logic          o_done;
  logic          o_rd_wren;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] o_rd_data;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  div_unit #(.DW(DW), .AW(AW)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .i_kill     (i_kill),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rd_wren  (o_rd_wren),
    .o_rd_addr  (o_rd_addr),
    .o_rd_data  (o_rd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Issue one request and wait for its strobe; lat counts edges after E0.
  task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [AW-1:0] rd,
                        input logic [DW-1:0] exp_d, input int exp_lat,
                        input string name);
    int  n;
    bit  seen;
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_rs1_data = a; i_rs2_data = b; i_rd_addr = rd;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n <= 40) begin
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
      else begin
        @(posedge i_clk);
        n++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no o_done within %0d edges", name, n);
      return;
    end
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d expected %0d", name, n, exp_lat);
    end
    checks++;
    if (o_rd_data !== exp_d) begin
      errors++;
      $display("FAIL %s data got %h expected %h", name, o_rd_data, exp_d);
    end
    checks++;
    if (o_rd_addr !== rd) begin
      errors++;
      $display("FAIL %s addr got %0d expected %0d", name, o_rd_addr, rd);
    end
    checks++;
    if (o_rd_wren !== (rd != '0)) begin
      errors++;
      $display("FAIL %s wren got %b expected %b", name, o_rd_wren, (rd != '0));
    end
    @(negedge i_clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_rd_data !== exp_d) begin
      errors++;
      $display("FAIL %s after-strobe done=%b busy=%b data=%h expected 0 0 %h",
               name, o_done, o_busy, o_rd_data, exp_d);
    end
    $display("op %s: a=%h b=%h rd=%0d -> %h lat=%0d", name, a, b, rd, o_rd_data, n);
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rd_wren !== 1'b0 ||
        o_rd_addr !== '0 || o_rd_data !== '0) begin
      errors++;
      $display("FAIL %s outputs busy=%b done=%b wren=%b addr=%0d data=%h expected all 0",
               name, o_busy, o_done, o_rd_wren, o_rd_addr, o_rd_data);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_op = '0; i_rs1_data = '0;
    i_rs2_data = '0; i_rd_addr = '0; i_kill = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_idle_zero("reset_held");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle_zero("reset_released");
    $display("reset: outputs busy=%b done=%b data=%h", o_busy, o_done, o_rd_data);
  endtask

  task automatic test_divide();
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 32, "divu_100_7");
    run_op(OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 32, "remu_100_7");
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 32, "rem_m7_2");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 32, "div_m7_2");
    run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, 32, "div_7_m2");
    run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1, 32, "rem_7_m2");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 32, "divu_max_1");
  endtask

  task automatic test_div_zero();
    run_op(OP_DIV,  32'h1234, 32'd0, 5'd11, 32'hFFFF_FFFF, 0, "div_by0");
    run_op(OP_DIVU, 32'h1234, 32'd0, 5'd12, 32'hFFFF_FFFF, 0, "divu_by0");
    run_op(OP_REMU, 32'h1234, 32'd0, 5'd13, 32'h1234, 0, "remu_by0");
    run_op(OP_REM,  32'h1234, 32'd0, 5'd14, 32'h1234, 0, "rem_by0");
  endtask

  task automatic test_overflow();
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 0, "rem_ovf");
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0, 32, "divu_big");
    run_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 32, "remu_big");
  endtask

  task automatic test_rd_zero();
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 32, "divu_rd0");
  endtask

  // Start held through CALC and DONE must not disturb the running op
  task automatic test_start_ignored();
    int  n;
    bit  seen;
    @(negedge i_clk);
    i_start = 1'b1; i_op = OP_DIVU; i_rs1_data = 32'd100; i_rs2_data = 32'd7;
    i_rd_addr = 5'd3;
    @(posedge i_clk);
    #1 i_rs1_data = 32'd50; i_rs2_data = 32'd5; i_rd_addr = 5'd9; i_op = OP_REMU;
    n = 0; seen = 1'b0;
    while (!seen && n <= 40) begin
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
      else begin
        @(posedge i_clk);
        n++;
      end
    end
    checks++;
    if (!seen || n !== 32 || o_rd_data !== 32'd14 || o_rd_addr !== 5'd3) begin
      errors++;
      $display("FAIL start_in_calc seen=%b lat=%0d data=%h addr=%0d expected 1 32 0000000e 3",
               seen, n, o_rd_data, o_rd_addr);
    end
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done busy got %b expected 0", o_busy);
    end
    i_start = 1'b0;
    $display("start_ignored: data=%h addr=%0d lat=%0d", o_rd_data, o_rd_addr, n);
  endtask

  task automatic test_kill();
    int n;
    bit seen;
    // kill together with start in IDLE: nothing accepted
    @(negedge i_clk);
    i_start = 1'b1; i_kill = 1'b1; i_op = OP_DIVU; i_rs1_data = 32'd9;
    i_rs2_data = 32'd3; i_rd_addr = 5'd4;
    @(posedge i_clk);
    #1 i_start = 1'b0; i_kill = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL kill_idle busy got %b expected 0", o_busy);
    end
    // kill at cycle 10 of CALC
    @(negedge i_clk);
    i_start = 1'b1; i_op = OP_DIVU; i_rs1_data = 32'd1000; i_rs2_data = 32'd10;
    i_rd_addr = 5'd20;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    i_kill = 1'b1;
    @(posedge i_clk);
    #1 i_kill = 1'b0;
    seen = 1'b0;
    @(negedge i_clk);
    if (o_done) seen = 1'b1;
    checks++;
    if (o_busy !== 1'b0 || seen) begin
      errors++;
      $display("FAIL kill_calc busy=%b done=%b expected 0 0", o_busy, seen);
    end
    $display("kill: busy=%b after kill in CALC", o_busy);
    // next request accepted right away and computes normally
    run_op(OP_DIVU, 32'd1000, 32'd10, 5'd21, 32'd100, 32, "after_kill");
    n = 0;
    if (n == 0) begin end
  endtask

  // Async reset mid-operation clears outputs at once and suppresses the strobe
  task automatic test_reset_mid();
    bit seen;
    @(negedge i_clk);
    i_start = 1'b1; i_op = OP_DIVU; i_rs1_data = 32'd77; i_rs2_data = 32'd7;
    i_rd_addr = 5'd2;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check_idle_zero("reset_mid_calc");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done || o_busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_strobe activity after release got 1 expected 0");
    end
    $display("reset_mid: data=%h busy=%b", o_rd_data, o_busy);
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_overflow();
    test_rd_zero();
    test_start_ignored();
    test_kill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
